// File: rtl/muldiv_hilo.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_hilo
//  Description : Execute-stage multi-cycle multiply/divide unit owning the
//                HI/LO register pair. MULT/MULTU take one MUL cycle and
//                DIV/DIVU take 32 restoring-division cycles. The unit stalls
//                the pipeline while an operation is in flight. MTHI/MTLO
//                write HI/LO directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_hilo (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  alucontrolE,
    input  logic        validE,
    input  logic        flushE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    output logic        stall_muldivE,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    // Operation codes, mirroring the ALU decoder's defines.vh
    localparam logic [7:0] c_op_mult  = 8'b0001_1000;
    localparam logic [7:0] c_op_multu = 8'b0001_1001;
    localparam logic [7:0] c_op_div   = 8'b0001_1010;
    localparam logic [7:0] c_op_divu  = 8'b0001_1011;
    localparam logic [7:0] c_op_mthi  = 8'b0001_0001;
    localparam logic [7:0] c_op_mtlo  = 8'b0001_0011;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_a;        // multiplicand, or dividend shifted out MSB first
    logic [31:0] r_b;        // multiplier / divisor magnitude
    logic [63:0] r_res;      // product, or {partial remainder, quotient}
    logic [31:0] r_araw;     // raw dividend, returned as HI on divide by zero
    logic [5:0]  r_cnt;
    logic        r_qsign;
    logic        r_rsign;
    logic        r_isdiv;
    logic        r_dz;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_signed;
    logic        w_sa;
    logic        w_sb;
    logic        w_start;
    logic        w_busy;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic        w_qbit;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_hi_new;
    logic [31:0] w_lo_new;

    // Operation decode, operand signs and the start/stall conditions
    always_comb begin
        w_is_mul = (alucontrolE == c_op_mult) || (alucontrolE == c_op_multu);
        w_is_div = (alucontrolE == c_op_div)  || (alucontrolE == c_op_divu);
        w_signed = (alucontrolE == c_op_mult) || (alucontrolE == c_op_div);
        w_sa     = w_signed & srcaE[31];
        w_sb     = w_signed & srcbE[31];
        w_start  = (r_state == c_st_idle) & validE & ~flushE & (w_is_mul | w_is_div);
        w_busy   = (r_state == c_st_mul) | (r_state == c_st_div);
        stall_muldivE = ~flushE & (w_start | w_busy);
    end

    // One restoring-division step: shift in the next dividend bit, trial subtract
    always_comb begin
        w_rem_sh = {r_res[63:32], r_a[31]};
        w_diff   = w_rem_sh - {1'b0, r_b};
        w_qbit   = ~w_diff[32];
    end

    // Sign fix-up of the unsigned result; divide by zero bypasses the datapath
    always_comb begin
        w_prod_fix = r_qsign ? (64'd0 - r_res) : r_res;
        w_quot_fix = r_qsign ? (32'd0 - r_res[31:0])  : r_res[31:0];
        w_rem_fix  = r_rsign ? (32'd0 - r_res[63:32]) : r_res[63:32];
        if (!r_isdiv) begin
            w_hi_new = w_prod_fix[63:32];
            w_lo_new = w_prod_fix[31:0];
        end else if (r_dz) begin
            w_hi_new = r_araw;
            w_lo_new = 32'hFFFF_FFFF;
        end else begin
            w_hi_new = w_rem_fix;
            w_lo_new = w_quot_fix;
        end
    end

    // Control FSM and multiply/divide datapath
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_st_idle;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_res   <= 64'd0;
            r_araw  <= 32'd0;
            r_cnt   <= 6'd0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
            r_isdiv <= 1'b0;
            r_dz    <= 1'b0;
        end else if (flushE) begin
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_a     <= w_sa ? (32'd0 - srcaE) : srcaE;
                        r_b     <= w_sb ? (32'd0 - srcbE) : srcbE;
                        r_araw  <= srcaE;
                        r_qsign <= w_sa ^ w_sb;
                        r_rsign <= w_sa;
                        r_isdiv <= w_is_div;
                        r_dz    <= w_is_div & (srcbE == 32'd0);
                        r_res   <= 64'd0;
                        r_cnt   <= 6'd0;
                        r_state <= w_is_div ? c_st_div : c_st_mul;
                    end
                end
                c_st_mul: begin
                    r_res   <= {32'd0, r_a} * {32'd0, r_b};
                    r_state <= c_st_done;
                end
                c_st_div: begin
                    r_res[63:32] <= w_qbit ? w_diff[31:0] : w_rem_sh[31:0];
                    r_res[31:0]  <= {r_res[30:0], w_qbit};
                    r_a          <= {r_a[30:0], 1'b0};
                    r_cnt        <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_state <= c_st_done;
                    end
                end
                default: begin
                    // DONE: result is written this cycle, never restarts here
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // HI/LO register pair: written on DONE or by MTHI/MTLO, never on a flush
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (!flushE) begin
            if (r_state == c_st_done) begin
                r_hi <= w_hi_new;
                r_lo <= w_lo_new;
            end else if ((r_state == c_st_idle) && validE) begin
                if (alucontrolE == c_op_mthi) begin
                    r_hi <= srcaE;
                end
                if (alucontrolE == c_op_mtlo) begin
                    r_lo <= srcaE;
                end
            end
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule
`default_nettype wire
